// File: rtl/iir_out_serializer.sv
// Decimates the IIR output stream, clips kept samples to OUT_W bits, buffers them in a small
// FIFO and shifts them out MSB-first with a one-bit frame strobe on the first bit of each word.
module iir_out_serializer #(
  parameter int unsigned IN_W       = 18,
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned DECIM      = 32,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IN_W-1:0] y_in,
  input  logic            in_en,
  input  logic            clr_flags,
  output logic            sd_out,
  output logic            sd_frame,
  output logic            busy,
  output logic            sat_flag,
  output logic [7:0]      drop_cnt
);

  localparam int unsigned DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned IW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  localparam logic [DW-1:0] DLast = DW'(DECIM - 1);
  localparam logic [CW-1:0] CntFull = CW'(FIFO_DEPTH);
  localparam logic [IW-1:0] IdxTop = IW'(OUT_W - 1);

  // Largest and smallest values representable in OUT_W bits, sign-extended to IN_W.
  localparam logic signed [IN_W-1:0] SatMax = {{(IN_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [IN_W-1:0] SatMin = {{(IN_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift
  } state_e;

  state_e            state_q;
  logic [DW-1:0]     dcnt_q;
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [OUT_W-1:0]  shreg_q;
  logic [IW-1:0]     idx_q;
  logic [OUT_W-1:0]  mem [FIFO_DEPTH];

  logic signed [IN_W-1:0] y_s;
  logic [OUT_W-1:0]       sat_word;
  logic                   clip;
  logic                   keep;
  logic                   push;
  logic                   pop;
  logic                   drop;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic [OUT_W-1:0]       head;

  assign y_s = signed'(y_in);

  always_comb begin
    sat_word = y_in[OUT_W-1:0];
    clip     = 1'b0;
    if (y_s > SatMax) begin
      sat_word = {1'b0, {(OUT_W - 1){1'b1}}};
      clip     = 1'b1;
    end else if (y_s < SatMin) begin
      sat_word = {1'b1, {(OUT_W - 1){1'b0}}};
      clip     = 1'b1;
    end
  end

  assign keep       = in_en && (dcnt_q == DLast);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntFull);
  // The LOAD state is the only consumer; it is entered only when the FIFO holds a word.
  assign pop        = (state_q == StLoad);
  assign push       = keep && (!fifo_full || pop);
  assign drop       = keep && !push;
  assign head       = mem[rd_ptr_q];

  // Decimation counter only moves on enabled samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt_q <= '0;
    end else if (in_en) begin
      dcnt_q <= keep ? '0 : dcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= sat_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      shreg_q  <= '0;
      idx_q    <= '0;
      sd_out   <= 1'b0;
      sd_frame <= 1'b0;
      busy     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          sd_out   <= 1'b0;
          sd_frame <= 1'b0;
          if (!fifo_empty) begin
            state_q <= StLoad;
            busy    <= 1'b1;
          end
        end
        StLoad: begin
          shreg_q  <= head;
          idx_q    <= IdxTop;
          sd_out   <= head[OUT_W-1];
          sd_frame <= 1'b1;
          busy     <= 1'b1;
          state_q  <= StShift;
        end
        StShift: begin
          sd_frame <= 1'b0;
          if (idx_q == '0) begin
            sd_out <= 1'b0;
            if (!fifo_empty) begin
              state_q <= StLoad;
            end else begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end
          end else begin
            idx_q  <= idx_q - 1'b1;
            sd_out <= shreg_q[idx_q - 1'b1];
          end
        end
        default: begin
          state_q  <= StIdle;
          sd_out   <= 1'b0;
          sd_frame <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // A set/increment event on the same edge as clr_flags takes priority over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (keep && clip) begin
        sat_flag <= 1'b1;
      end else if (clr_flags) begin
        sat_flag <= 1'b0;
      end

      if (drop) begin
        if (clr_flags) begin
          drop_cnt <= 8'd1;
        end else if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end else if (clr_flags) begin
        drop_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_iir_out_serializer.sv
// Directed bench for iir_out_serializer: one instance with DECIM=4, one with DECIM=1,
// sharing stimulus; each test only inspects the instance it targets.
module tb_iir_out_serializer;

  logic        clk;
  logic        rst_n;
  logic [17:0] y_in;
  logic        in_en;
  logic        clr_flags;

  logic       sd_out_a, sd_frame_a, busy_a, sat_a;
  logic [7:0] drop_a;
  logic       sd_out_b, sd_frame_b, busy_b, sat_b;
  logic [7:0] drop_b;

  iir_out_serializer #(
    .IN_W(18), .OUT_W(16), .DECIM(4), .FIFO_DEPTH(8)
  ) u_dut_d4 (
    .clk(clk), .rst_n(rst_n), .y_in(y_in), .in_en(in_en), .clr_flags(clr_flags),
    .sd_out(sd_out_a), .sd_frame(sd_frame_a), .busy(busy_a), .sat_flag(sat_a),
    .drop_cnt(drop_a)
  );

  iir_out_serializer #(
    .IN_W(18), .OUT_W(16), .DECIM(1), .FIFO_DEPTH(8)
  ) u_dut_d1 (
    .clk(clk), .rst_n(rst_n), .y_in(y_in), .in_en(in_en), .clr_flags(clr_flags),
    .sd_out(sd_out_b), .sd_frame(sd_frame_b), .busy(busy_b), .sat_flag(sat_b),
    .drop_cnt(drop_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serial capture state
  int          cap_k;
  int          fr_at[$];
  logic [15:0] words[$];
  int          nbusy;
  int          stray;
  bit          collecting;
  int          bitcnt;
  logic [15:0] acc;

  task automatic cap_clear();
    cap_k = 0;
    fr_at.delete();
    words.delete();
    nbusy = 0;
    stray = 0;
    collecting = 0;
    bitcnt = 0;
    acc = '0;
  endtask

  task automatic sample(input bit sel);
    logic sd, fr, bz;
    sd = sel ? sd_out_b : sd_out_a;
    fr = sel ? sd_frame_b : sd_frame_a;
    bz = sel ? busy_b : busy_a;
    if (fr === 1'b1) begin
      fr_at.push_back(cap_k);
      collecting = 1;
      bitcnt = 0;
      acc = '0;
    end
    if (collecting) begin
      acc = {acc[14:0], sd};
      bitcnt++;
      if (bitcnt == 16) begin
        words.push_back(acc);
        collecting = 0;
      end
    end else if (sd !== 1'b0) begin
      stray++;
    end
    if (bz === 1'b1) nbusy++;
    cap_k++;
  endtask

  task automatic do_reset();
    in_en = 1'b0;
    clr_flags = 1'b0;
    y_in = '0;
    rst_n = 1'b0;
    #1;
    check("rst_sd_out", {sd_out_a, sd_out_b}, 0);
    check("rst_sd_frame", {sd_frame_a, sd_frame_b}, 0);
    check("rst_busy", {busy_a, busy_b}, 0);
    check("rst_sat_flag", {sat_a, sat_b}, 0);
    check("rst_drop_cnt", {drop_a, drop_b}, 0);
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  int exp3[20] = '{4, 8, 12, 16, 20, 24, 28, 32, 36, 40, 44,
                   60, 76, 92, 108, 128, 144, 160, 176, 196};

  initial begin
    int bad;
    rst_n = 1'b1;
    in_en = 1'b0;
    clr_flags = 1'b0;
    y_in = '0;
    #2;

    // Test 1: single word, latency, frame width, busy length
    do_reset();
    in_en = 1'b1;
    y_in = 18'sd5;
    repeat (4) tick();
    in_en = 1'b0;
    y_in = '0;
    cap_clear();
    repeat (25) begin
      sample(0);
      tick();
    end
    check("t1_frame_count", fr_at.size(), 1);
    check("t1_frame_at", fr_at.size() > 0 ? fr_at[0] : -1, 2);
    check("t1_word", words.size() > 0 ? words[0] : 16'hDEAD, 16'h0005);
    check("t1_busy_cycles", nbusy, 17);
    check("t1_stray", stray, 0);
    check("t1_sat", sat_a, 0);

    // Test 2: saturation both ways, back-to-back words
    do_reset();
    check("t2_sat_pre", sat_b, 0);
    in_en = 1'b1;
    y_in = 18'sd70000;
    tick();
    check("t2_sat_first_edge", sat_b, 1);
    y_in = -18'sd70000;
    tick();
    y_in = -18'sd2;
    tick();
    in_en = 1'b0;
    y_in = '0;
    cap_clear();
    repeat (55) begin
      sample(1);
      tick();
    end
    check("t2_frame_count", fr_at.size(), 3);
    check("t2_word0", words.size() > 0 ? words[0] : 16'hDEAD, 16'h7FFF);
    check("t2_word1", words.size() > 1 ? words[1] : 16'hDEAD, 16'h8000);
    check("t2_word2", words.size() > 2 ? words[2] : 16'hDEAD, 16'hFFFE);
    check("t2_frame0_at", fr_at.size() > 0 ? fr_at[0] : -1, 0);
    check("t2_gap01", fr_at.size() > 1 ? fr_at[1] - fr_at[0] : -1, 17);
    check("t2_gap12", fr_at.size() > 2 ? fr_at[2] - fr_at[1] : -1, 17);

    // Test 3: overflow with incrementing samples
    do_reset();
    cap_clear();
    in_en = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      y_in = 18'(i);
      tick();
      sample(0);
      if (i == 47) check("t3_drop_e47", drop_a, 0);
      if (i == 48) check("t3_drop_e48", drop_a, 1);
      if (i == 107) check("t3_drop_e107", drop_a, 12);
      if (i == 108) check("t3_drop_full_push_pop", drop_a, 12);
      if (i == 112) check("t3_drop_e112", drop_a, 13);
    end
    in_en = 1'b0;
    y_in = '0;
    repeat (160) begin
      tick();
      sample(0);
    end
    check("t3_drop_final", drop_a, 30);
    check("t3_word_count", words.size(), 20);
    for (int j = 0; j < 20; j++) begin
      check($sformatf("t3_word%0d", j), j < words.size() ? words[j] : 16'hDEAD, exp3[j]);
    end
    bad = 0;
    for (int j = 1; j < fr_at.size(); j++) begin
      if (fr_at[j] - fr_at[j-1] != 17) bad++;
    end
    check("t3_no_gaps", bad, 0);
    check("t3_stray", stray, 0);

    // Test 4: disabled cycles do not advance the decimator
    do_reset();
    for (int i = 0; i < 7; i++) begin
      in_en = (i % 2 == 0);
      y_in = 18'(3 + i);
      tick();
      if (i == 5) check("t4_no_early_keep", busy_a, 0);
    end
    in_en = 1'b0;
    y_in = '0;
    cap_clear();
    repeat (25) begin
      sample(0);
      tick();
    end
    check("t4_frame_count", fr_at.size(), 1);
    check("t4_frame_at", fr_at.size() > 0 ? fr_at[0] : -1, 2);
    check("t4_word", words.size() > 0 ? words[0] : 16'hDEAD, 16'h0009);

    // Test 5: asynchronous reset mid-word with words queued
    do_reset();
    in_en = 1'b1;
    y_in = 18'd1000;
    tick();
    y_in = 18'd2000;
    tick();
    y_in = 18'd3000;
    tick();
    y_in = 18'd4000;
    tick();
    in_en = 1'b0;
    y_in = '0;
    repeat (7) tick();
    check("t5_bit7_pre", sd_out_b, 1);
    check("t5_busy_pre", busy_b, 1);
    rst_n = 1'b0;
    #1;
    check("t5_async_sd_out", sd_out_b, 0);
    check("t5_async_busy", busy_b, 0);
    check("t5_async_frame", sd_frame_b, 0);
    #2;
    rst_n = 1'b1;
    cap_clear();
    repeat (60) begin
      tick();
      sample(1);
    end
    check("t5_no_frames", fr_at.size(), 0);
    check("t5_no_busy", nbusy, 0);
    check("t5_drop", drop_b, 0);

    // Test 6: clear versus same-edge events
    do_reset();
    in_en = 1'b1;
    y_in = 18'sd40000;
    repeat (14) tick();
    check("t6_drop_pre", drop_b, 5);
    check("t6_sat_pre", sat_b, 1);
    in_en = 1'b0;
    repeat (6) tick();
    check("t6_drop_hold", drop_b, 5);
    in_en = 1'b1;
    clr_flags = 1'b1;
    tick();
    in_en = 1'b0;
    check("t6_sat_event_wins", sat_b, 1);
    check("t6_drop_cleared", drop_b, 0);
    tick();
    check("t6_sat_cleared", sat_b, 0);
    in_en = 1'b1;
    tick();
    in_en = 1'b0;
    clr_flags = 1'b0;
    check("t6_drop_event_wins", drop_b, 1);

    // drop_cnt saturates at 255
    do_reset();
    in_en = 1'b1;
    y_in = 18'sd5;
    repeat (400) tick();
    in_en = 1'b0;
    check("t7_drop_saturates", drop_b, 255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
